mmio_uart_tx: RTL and testbench

MMIO_UART_TX -- requirements
Module: mmio_uart_tx

---
 rtl/mmio_uart_tx_pkg.sv | 47 ++++
 rtl/tx_fifo.sv | 67 ++++++
 rtl/mmio_uart_tx.sv | 166 ++++++++++++++++
 tb/tb_mmio_uart_tx.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_uart_tx_pkg.sv
// Shared definitions for the memory-mapped UART transmitter.
// Holds the FSM state encoding, the status-word bit positions, the default
// register addresses and a helper that packs the status word.
package mmio_uart_tx_pkg;

    localparam int unsigned ADDR_W  = 8;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned BYTE_W  = 8;
    localparam int unsigned COUNT_W = 4;   // holds 0..8 entries
    localparam int unsigned BAUD_W  = 16;  // holds CLKS_PER_BIT-1 up to 65534

    localparam logic [ADDR_W-1:0] DEFAULT_TX_ADDR   = 8'hFF;
    localparam logic [ADDR_W-1:0] DEFAULT_STAT_ADDR = 8'hFE;

    // Status word bit positions
    localparam int unsigned STAT_ACTIVE    = 0;
    localparam int unsigned STAT_FULL      = 1;
    localparam int unsigned STAT_EMPTY     = 2;
    localparam int unsigned STAT_OVERFLOW  = 3;
    localparam int unsigned STAT_COUNT_LSB = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    // Pack the status fields into the 32-bit load word
    function automatic logic [DATA_W-1:0] status_word(
        input logic               active,
        input logic               full,
        input logic               empty,
        input logic               overflow,
        input logic [COUNT_W-1:0] count
    );
        logic [DATA_W-1:0] w;
        w                                 = '0;
        w[STAT_ACTIVE]                    = active;
        w[STAT_FULL]                      = full;
        w[STAT_EMPTY]                     = empty;
        w[STAT_OVERFLOW]                  = overflow;
        w[STAT_COUNT_LSB +: COUNT_W]      = count;
        return w;
    endfunction

endpackage

// File: rtl/tx_fifo.sv
// Transmit byte FIFO.
// Ports: clock/clear (async active-high), push/din write side, pop/head_c read
// side, registered full/empty/count, accept_c (push taken this cycle) and
// empty_next_c (emptiness after this edge) for the owner's status logic.
// A push while full is taken only when a pop happens in the same cycle.
module tx_fifo
    import mmio_uart_tx_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic               clock,
    input  logic               clear,
    input  logic               push,
    input  logic               pop,
    input  logic [BYTE_W-1:0]  din,
    output logic [BYTE_W-1:0]  head_c,
    output logic               full,
    output logic               empty,
    output logic [COUNT_W-1:0] count,
    output logic               accept_c,
    output logic               empty_next_c
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [BYTE_W-1:0]  mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic               pop_ok;
    logic [COUNT_W-1:0] count_d;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : PTR_W'(p + PTR_W'(1));
    endfunction

    // Accept/pop qualification and next occupancy
    always_comb begin
        pop_ok       = pop && !empty;
        accept_c     = push && (!full || pop_ok);
        count_d      = count + COUNT_W'(accept_c) - COUNT_W'(pop_ok);
        empty_next_c = (count_d == '0);
        head_c       = mem[rd_ptr];
    end

    // Pointers and occupancy flags
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (accept_c) wr_ptr <= next_ptr(wr_ptr);
            if (pop_ok)   rd_ptr <= next_ptr(rd_ptr);
            count <= count_d;
            full  <= (count_d == COUNT_W'(DEPTH));
            empty <= (count_d == '0);
        end
    end

    // Storage needs no reset; pointers define validity
    always_ff @(posedge clock) begin
        if (accept_c) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter with a small byte FIFO.
// Ports: clock, clear (async active-high), ADDR/DIN/wren store interface,
// DOUT registered load data (status at STAT_ADDR, zero elsewhere),
// tx serial line (idle high), txBusy (frame on line or bytes buffered).
module mmio_uart_tx
    import mmio_uart_tx_pkg::*;
#(
    parameter int unsigned       CLKS_PER_BIT = 16,
    parameter int unsigned       FIFO_DEPTH   = 4,
    parameter logic [ADDR_W-1:0] TX_ADDR      = DEFAULT_TX_ADDR,
    parameter logic [ADDR_W-1:0] STAT_ADDR    = DEFAULT_STAT_ADDR
) (
    input  logic              clock,
    input  logic              clear,
    input  logic [ADDR_W-1:0] ADDR,
    input  logic [DATA_W-1:0] DIN,
    input  logic              wren,
    output logic [DATA_W-1:0] DOUT,
    output logic              tx,
    output logic              txBusy
);

    uart_state_t        state_q, state_d;
    logic [BAUD_W-1:0]  cnt_q, cnt_d, cnt_inc;
    logic [2:0]         bit_q, bit_d, bit_nxt;
    logic [BYTE_W-1:0]  shift_q, shift_d;
    logic               tx_d;
    logic               bit_end;
    logic               pop;

    logic               push_req;
    logic               stat_wr;
    logic               overflow_q, overflow_d;
    logic               busy_d;
    logic [DATA_W-1:0]  dout_d;

    logic [BYTE_W-1:0]  fifo_head;
    logic               fifo_full;
    logic               fifo_empty;
    logic [COUNT_W-1:0] fifo_count;
    logic               fifo_accept;
    logic               fifo_empty_next;

    logic               unused_din;
    assign unused_din = ^DIN[DATA_W-1:BYTE_W];

    tx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock        (clock),
        .clear        (clear),
        .push         (push_req),
        .pop          (pop),
        .din          (DIN[BYTE_W-1:0]),
        .head_c       (fifo_head),
        .full         (fifo_full),
        .empty        (fifo_empty),
        .count        (fifo_count),
        .accept_c     (fifo_accept),
        .empty_next_c (fifo_empty_next)
    );

    // Bit timing helpers; the counter restarts at 0 on every bit boundary
    always_comb begin
        bit_end = (cnt_q == BAUD_W'(CLKS_PER_BIT - 1));
        cnt_inc = cnt_q + BAUD_W'(1);
        bit_nxt = bit_q + 3'd1;
    end

    // Frame FSM: next state, shifter and next line level
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                tx_d  = 1'b1;
                cnt_d = '0;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = fifo_head;
                    tx_d    = 1'b0;
                    state_d = START;
                end
            end
            START: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    tx_d    = shift_q[0];
                    state_d = DATA;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            DATA: begin
                if (bit_end) begin
                    cnt_d = '0;
                    if (bit_q == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = STOP;
                    end else begin
                        bit_d = bit_nxt;
                        tx_d  = shift_q[bit_nxt];
                    end
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            STOP: begin
                tx_d = 1'b1;
                if (bit_end) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Register decode, sticky overflow, busy and load data
    always_comb begin
        push_req   = wren && (ADDR == TX_ADDR);
        stat_wr    = wren && (ADDR == STAT_ADDR);
        overflow_d = overflow_q;
        if (stat_wr)
            overflow_d = 1'b0;
        else if (push_req && !fifo_accept)
            overflow_d = 1'b1;
        busy_d = (state_d != IDLE) || !fifo_empty_next;
        dout_d = '0;
        if (ADDR == STAT_ADDR)
            dout_d = status_word(state_q != IDLE, fifo_full, fifo_empty,
                                 overflow_q, fifo_count);
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            tx         <= 1'b1;
            txBusy     <= 1'b0;
            overflow_q <= 1'b0;
            DOUT       <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            tx         <= tx_d;
            txBusy     <= busy_d;
            overflow_q <= overflow_d;
            DOUT       <= dout_d;
        end
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Self-checking bench for mmio_uart_tx (CLKS_PER_BIT=4, FIFO_DEPTH=4).
// A frame-timeline reference model predicts tx/txBusy/DOUT every cycle, and a
// line receiver decodes the serial output into bytes for order checks.
module tb_mmio_uart_tx;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int FRAME = 10 * CPB;
    localparam logic [7:0] A_TX = 8'hFF;
    localparam logic [7:0] A_ST = 8'hFE;

    logic        clock = 1'b0;
    logic        clear = 1'b0;
    logic [7:0]  ADDR  = 8'h00;
    logic [31:0] DIN   = 32'h0;
    logic        wren  = 1'b0;
    logic [31:0] DOUT;
    logic        tx;
    logic        txBusy;

    mmio_uart_tx #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH),
        .TX_ADDR      (A_TX),
        .STAT_ADDR    (A_ST)
    ) dut (
        .clock  (clock),
        .clear  (clear),
        .ADDR   (ADDR),
        .DIN    (DIN),
        .wren   (wren),
        .DOUT   (DOUT),
        .tx     (tx),
        .txBusy (txBusy)
    );

    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: byte queue plus the edge at which the current frame began
    int         e = 0;
    logic [7:0] q[$];
    bit         have_frame = 0;
    int         s = 0;
    logic [7:0] fb = 8'h00;
    bit         m_ovf = 0;

    // Line receiver and timing capture
    bit         rx_busy = 0;
    int         rx_pos = 0;
    logic [7:0] rx_byte = 8'h00;
    logic [7:0] rx_q[$];
    int         start_es[$];
    logic       prev_busy = 1'b0;
    int         busy_fall_e = 0;

    typedef struct {
        logic [7:0]  addr;
        logic [31:0] din;
        logic        wr;
        logic        exp_tx;
        logic        exp_busy;
        logic [31:0] exp_dout;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @edge %0d: got %h expected %h", name, e, act, exp);
        end
    endtask

    function automatic bit act_after(int x);
        return have_frame && (x >= s) && ((x - s) < FRAME);
    endfunction

    function automatic logic line_after(int x);
        int p;
        if (!act_after(x)) return 1'b1;
        p = (x - s) / CPB;
        if (p == 0) return 1'b0;
        if (p <= 8) return fb[p-1];
        return 1'b1;
    endfunction

    function automatic logic [31:0] model_status(int pre_e);
        logic [31:0] w;
        w      = 32'h0;
        w[0]   = act_after(pre_e - 1);
        w[1]   = (q.size() == DEPTH);
        w[2]   = (q.size() == 0);
        w[3]   = m_ovf;
        w[7:4] = 4'(q.size());
        return w;
    endfunction

    task automatic model_reset();
        q.delete();
        have_frame = 0;
        m_ovf      = 0;
        rx_busy    = 0;
        prev_busy  = 1'b0;
    endtask

    task automatic rx_sample();
        if (!rx_busy) begin
            if (tx === 1'b0) begin
                rx_busy = 1;
                rx_pos  = 0;
                start_es.push_back(e);
            end
        end else begin
            rx_pos++;
            if ((rx_pos % CPB) == CPB / 2 && rx_pos / CPB >= 1 && rx_pos / CPB <= 8)
                rx_byte[rx_pos / CPB - 1] = tx;
            if (rx_pos == 9 * CPB + CPB / 2) begin
                chk("stop_bit", tx, 1'b1);
                rx_q.push_back(rx_byte);
            end
            if (rx_pos == FRAME - 1) rx_busy = 0;
        end
    endtask

    // One clock: drive at negedge, advance model at posedge, compare at next negedge
    task automatic step(input logic [7:0] a, input logic [31:0] d, input logic w);
        logic [31:0] st;
        logic [31:0] exp_dout;
        logic        exp_tx;
        logic        exp_busy;
        bit          do_pop;
        bit          full_pre;
        ADDR = a;
        DIN  = d;
        wren = w;
        @(posedge clock);
        e++;
        st       = model_status(e);
        do_pop   = !act_after(e - 1) && (q.size() > 0);
        full_pre = (q.size() == DEPTH);
        if (do_pop) begin
            fb         = q.pop_front();
            s          = e;
            have_frame = 1;
        end
        if (w && a == A_TX) begin
            if (!full_pre || do_pop) q.push_back(d[7:0]);
            else m_ovf = 1;
        end
        if (w && a == A_ST) m_ovf = 0;
        exp_dout = (a == A_ST) ? st : 32'h0;
        exp_tx   = line_after(e);
        exp_busy = act_after(e) || (q.size() > 0);
        @(negedge clock);
        chk("cycle{tx,busy,dout}", {tx, txBusy, DOUT}, {exp_tx, exp_busy, exp_dout});
        rx_sample();
        if (prev_busy && !txBusy) busy_fall_e = e;
        prev_busy = txBusy;
    endtask

    task automatic idle(input int n, input logic [7:0] a);
        for (int i = 0; i < n; i++) step(a, 32'h0, 1'b0);
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((txBusy || rx_busy) && n < budget) begin
            step(8'h00, 32'h0, 1'b0);
            n++;
        end
        chk("drain_in_budget", (n < budget), 1'b1);
    endtask

    // Async reset pulse entirely inside the low clock phase
    task automatic reset_async();
        ADDR = 8'h00;
        wren = 1'b0;
        #2 clear = 1'b1;
        #1;
        chk("rst_tx", tx, 1'b1);
        chk("rst_busy", txBusy, 1'b0);
        chk("rst_dout", DOUT, 32'h0);
        #1 clear = 1'b0;
        model_reset();
        @(negedge clock);
    endtask

    task automatic expect_rx(input string name, input logic [7:0] exp[$]);
        chk({name, "_count"}, rx_q.size(), exp.size());
        for (int i = 0; i < exp.size() && i < rx_q.size(); i++)
            chk({name, "_byte"}, rx_q[i], exp[i]);
        rx_q.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t       vecs[$];
        logic [7:0] exp_b[$];
        int         guard;
        int         r;

        // Reset state, observed without any clock edge
        #1 clear = 1'b1;
        #2;
        chk("init_tx", tx, 1'b1);
        chk("init_busy", txBusy, 1'b0);
        chk("init_dout", DOUT, 32'h0);
        @(negedge clock);
        clear = 1'b0;
        model_reset();

        // Directed single-byte vectors: store 0x41, then watch start and first data bit
        vecs.push_back('{8'hFE, 32'h0,  1'b0, 1'b1, 1'b0, 32'h04});
        vecs.push_back('{8'h10, 32'h0,  1'b0, 1'b1, 1'b0, 32'h00});
        vecs.push_back('{8'hFF, 32'h41, 1'b1, 1'b1, 1'b1, 32'h00});
        vecs.push_back('{8'hFE, 32'h0,  1'b0, 1'b0, 1'b1, 32'h10});
        vecs.push_back('{8'hFE, 32'h0,  1'b0, 1'b0, 1'b1, 32'h05});
        vecs.push_back('{8'hFE, 32'h9,  1'b1, 1'b0, 1'b1, 32'h05});
        vecs.push_back('{8'h00, 32'h0,  1'b0, 1'b0, 1'b1, 32'h00});
        vecs.push_back('{8'h00, 32'h0,  1'b0, 1'b1, 1'b1, 32'h00});
        vecs.push_back('{8'hFE, 32'h0,  1'b0, 1'b1, 1'b1, 32'h05});
        start_es.delete();
        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].addr, vecs[i].din, vecs[i].wr);
            chk("vec_tx", tx, vecs[i].exp_tx);
            chk("vec_busy", txBusy, vecs[i].exp_busy);
            chk("vec_dout", DOUT, vecs[i].exp_dout);
        end
        wait_idle(100);
        exp_b = '{8'h41};
        expect_rx("single", exp_b);
        chk("single_starts", start_es.size(), 1);
        if (start_es.size() > 0) chk("busy_low_after_start", busy_fall_e - start_es[0], FRAME);

        // Back-to-back frames: start bits 41 cycles apart
        start_es.delete();
        step(A_TX, 32'h55, 1'b1);
        step(A_TX, 32'hAA, 1'b1);
        wait_idle(150);
        chk("b2b_starts", start_es.size(), 2);
        if (start_es.size() == 2) chk("b2b_spacing", start_es[1] - start_es[0], FRAME + 1);
        exp_b = '{8'h55, 8'hAA};
        expect_rx("b2b", exp_b);

        // Status read with two bytes queued behind an active frame
        step(A_TX, 32'h11, 1'b1);
        step(A_TX, 32'h22, 1'b1);
        step(A_TX, 32'h33, 1'b1);
        step(A_ST, 32'h0, 1'b0);
        chk("stat_two_queued", DOUT, 32'h21);
        step(8'h10, 32'h0, 1'b0);
        chk("other_addr_zero", DOUT, 32'h0);
        wait_idle(200);
        exp_b = '{8'h11, 8'h22, 8'h33};
        expect_rx("stat", exp_b);

        // Overflow: six consecutive stores, the last one dropped
        for (int i = 0; i < 6; i++) step(A_TX, 32'h30 + i, 1'b1);
        step(A_ST, 32'h0, 1'b0);
        chk("ovf_status", DOUT, 32'h4B);
        step(A_ST, 32'h0, 1'b1);
        step(A_ST, 32'h0, 1'b0);
        chk("ovf_cleared", DOUT, 32'h43);
        wait_idle(300);
        exp_b = '{8'h30, 8'h31, 8'h32, 8'h33, 8'h34};
        expect_rx("ovf", exp_b);

        // Reset during data bit 3 (0xF0 has bit3 low), queued byte discarded
        step(A_TX, 32'hF0, 1'b1);
        step(A_TX, 32'hF1, 1'b1);
        idle(17, A_ST);
        chk("pre_reset_line_low", tx, 1'b0);
        reset_async();
        step(A_ST, 32'h0, 1'b0);
        chk("post_reset_status", DOUT, 32'h04);
        step(A_TX, 32'h7E, 1'b1);
        step(8'h00, 32'h0, 1'b0);
        chk("post_reset_start", tx, 1'b0);
        wait_idle(100);
        exp_b = '{8'h7E};
        expect_rx("post_reset", exp_b);

        // Push-while-full on pop cycles, order preserved across pointer wrap
        exp_b.delete();
        for (int i = 0; i < 5; i++) begin
            step(A_TX, 32'hA0 + i, 1'b1);
            exp_b.push_back(8'(8'hA0 + i));
        end
        for (int i = 5; i < 12; i++) begin
            guard = 0;
            while (!(!act_after(e) && q.size() > 0) && guard < 100) begin
                step(8'h00, 32'h0, 1'b0);
                guard++;
            end
            chk("wrap_pop_found", (guard < 100), 1'b1);
            chk("wrap_full_at_push", q.size(), DEPTH);
            step(A_TX, 32'hA0 + i, 1'b1);
            exp_b.push_back(8'(8'hA0 + i));
        end
        step(A_ST, 32'h0, 1'b0);
        chk("wrap_no_ovf", DOUT[3], 1'b0);
        wait_idle(600);
        expect_rx("wrap", exp_b);

        // Randomized traffic against the model
        for (int i = 0; i < 1500; i++) begin
            r = $urandom_range(0, 199);
            if (r < 12)       step(A_TX, $urandom, 1'b1);
            else if (r < 16)  step(A_ST, $urandom, 1'b1);
            else if (r < 60)  step(A_ST, 32'h0, 1'b0);
            else if (r < 198) step(8'($urandom_range(0, 255)), $urandom, 1'($urandom_range(0, 1)));
            else              reset_async();
        end
        wait_idle(400);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
